mem_access_unit: RTL

Bus initiator for the byte-wide `MainMemory` (16 Ki × 8, synchronous read, 16-bit data ports of which only bits [7:0] are stored). Control issues 16-bit word read/write requests through a valid/ready handshake. The unit splits each request into two byte accesses at A and A+1, assembles or splits the word, and returns a one-cycle response. It sits between `Control` (MAR/MBR traffic) and `MainMemory`, and drives the memory's `addr`, `data_in` and `write_enable` pins.

---
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Word-wide bus initiator for byte-wide MainMemory: splits each 16-bit request into two byte accesses at A and A+1.
// Optional MEM_ACCESS_BIG_ENDIAN_EN puts word[15:8] at byte A; the default build is little-endian.
module mem_access_unit #(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_write_enable,
  input  logic [15:0] mem_data_out
);

  localparam logic [15:0] MAX_ADDR = 16'(MEM_DEPTH - 2);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    WR0  = 3'd4,
    WR1  = 3'd5,
    RESP = 3'd6
  } state_t;

  state_t      state;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  lo_q;

  // Only the low byte of the memory data port carries storage.
  logic unused_mem_hi;
  assign unused_mem_hi = ^mem_data_out[15:8];

`ifdef MEM_ACCESS_BIG_ENDIAN_EN
  function automatic logic [7:0] byte_at_a(input logic [15:0] w);
    return w[15:8];
  endfunction
  function automatic logic [7:0] byte_at_a1(input logic [15:0] w);
    return w[7:0];
  endfunction
  function automatic logic [15:0] assemble(input logic [7:0] b_a, input logic [7:0] b_a1);
    return {b_a, b_a1};
  endfunction
`else
  function automatic logic [7:0] byte_at_a(input logic [15:0] w);
    return w[7:0];
  endfunction
  function automatic logic [7:0] byte_at_a1(input logic [15:0] w);
    return w[15:8];
  endfunction
  function automatic logic [15:0] assemble(input logic [7:0] b_a, input logic [7:0] b_a1);
    return {b_a1, b_a};
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      addr_q           <= 16'h0;
      wdata_q          <= 16'h0;
      lo_q             <= 8'h0;
      req_ready        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_rdata       <= 16'h0;
      resp_err         <= 1'b0;
      mem_addr         <= 16'h0;
      mem_data_in      <= 16'h0;
      mem_write_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_addr > MAX_ADDR) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 16'h0;
            end else if (req_write) begin
              state            <= WR0;
              mem_addr         <= req_addr;
              mem_data_in      <= {8'h00, byte_at_a(req_wdata)};
              mem_write_enable <= 1'b1;
            end else begin
              state    <= RD0;
              mem_addr <= req_addr;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD0: begin
          state    <= RD1;
          mem_addr <= addr_q + 16'd1;
        end
        // Synchronous memory: byte A appears during RD1, byte A+1 during RD2.
        RD1: begin
          state <= RD2;
          lo_q  <= mem_data_out[7:0];
        end
        RD2: begin
          state      <= RESP;
          mem_addr   <= 16'h0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= assemble(lo_q, mem_data_out[7:0]);
        end
        WR0: begin
          state       <= WR1;
          mem_addr    <= addr_q + 16'd1;
          mem_data_in <= {8'h00, byte_at_a1(wdata_q)};
        end
        WR1: begin
          state            <= RESP;
          mem_addr         <= 16'h0;
          mem_data_in      <= 16'h0;
          mem_write_enable <= 1'b0;
          resp_valid       <= 1'b1;
          resp_err         <= 1'b0;
          resp_rdata       <= 16'h0;
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 16'h0;
        end
        default: begin
          state            <= IDLE;
          req_ready        <= 1'b0;
          resp_valid       <= 1'b0;
          resp_err         <= 1'b0;
          resp_rdata       <= 16'h0;
          mem_addr         <= 16'h0;
          mem_data_in      <= 16'h0;
          mem_write_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
